// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush, occupancy and stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry (main + skid) build; default is one entry.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt
);

    logic              main_v_q, main_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [15:0]       stall_q, stall_d;
    logic              in_fire, out_fire;

    assign out_fire = main_v_q & out_ready;
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        stall_d = stall_q;
        if (main_v_q && !out_ready && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              rdy_q, rdy_d;

    assign in_ready  = rdy_q & ~flush & reset;
    assign occupancy = {skid_v_q, main_v_q & ~skid_v_q};

    // Empty slots are zeroed so out_ctrl reads as a no-op bubble straight from the register.
    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            main_v_d    = 1'b0;
            main_data_d = '0;
            main_ctrl_d = '0;
            skid_v_d    = 1'b0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end else if (out_fire) begin
            if (skid_v_q) begin
                main_data_d = skid_data_q;
                main_ctrl_d = skid_ctrl_q;
                skid_v_d    = 1'b0;
                skid_data_d = '0;
                skid_ctrl_d = '0;
            end else if (in_fire) begin
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
            end else begin
                main_v_d    = 1'b0;
                main_data_d = '0;
                main_ctrl_d = '0;
            end
        end else if (in_fire) begin
            if (main_v_q) begin
                skid_v_d    = 1'b1;
                skid_data_d = in_data;
                skid_ctrl_d = in_ctrl;
            end else begin
                main_v_d    = 1'b1;
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
            end
        end
        rdy_d = ~skid_v_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            rdy_q       <= 1'b1;
            stall_q     <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            rdy_q       <= rdy_d;
            stall_q     <= stall_d;
        end
    end
`else
    assign in_ready  = (~main_v_q | out_ready) & ~flush & reset;
    assign occupancy = {1'b0, main_v_q};

    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        if (flush || (out_fire && !in_fire)) begin
            main_v_d    = 1'b0;
            main_data_d = '0;
            main_ctrl_d = '0;
        end else if (in_fire) begin
            main_v_d    = 1'b1;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            stall_q     <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            stall_q     <= stall_d;
        end
    end
`endif

    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; honours PIPE_STAGE_SKID_EN to pick the expected depth.
module tb_pipe_stage_reg;
    localparam int DW = 96;
    localparam int CW = 16;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } entry_t;

    entry_t      sb[$];
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned stall_m = 0;
    bit          known = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        if (!reset || flush) return 1'b0;
        if (DEPTH == 2) return sb.size() < 2;
        return (sb.size() == 0) || out_ready;
    endfunction

    // One clock: drive at negedge, compare just after, update the model at posedge.
    task automatic cycle(input logic rst, input logic fl, input logic iv,
                         input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input bit chk);
        logic   rdy;
        entry_t e;
        @(negedge clk);
        reset = rst; flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
        #1;
        rdy = exp_ready();
        if (known && chk) begin
            check_eq("out_valid", 128'(out_valid), 128'(sb.size() != 0));
            check_eq("occupancy", 128'(occupancy), 128'(sb.size()));
            check_eq("in_ready", 128'(in_ready), 128'(rdy));
            check_eq("stall_cnt", 128'(stall_cnt), 128'(stall_m));
            if (sb.size() != 0) begin
                check_eq("out_data", 128'(out_data), 128'(sb[0].d));
                check_eq("out_ctrl", 128'(out_ctrl), 128'(sb[0].c));
            end else begin
                check_eq("bubble_ctrl", 128'(out_ctrl), 128'(0));
            end
        end
        @(posedge clk);
        if (!rst) begin
            sb.delete();
            stall_m = 0;
            known = 1;
        end else begin
            if (sb.size() != 0 && !ordy && stall_m != 16'hFFFF) stall_m++;
            if (sb.size() != 0 && ordy) void'(sb.pop_front());
            if (fl) sb.delete();
            else if (iv && rdy) begin
                e.d = d;
                e.c = c;
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;

        // reset with in_valid asserted
        cycle(0, 0, 1, 96'hDEAD, 16'hBEEF, 1, 1);
        cycle(0, 0, 1, 96'hDEAD, 16'hBEEF, 1, 1);
        cycle(1, 0, 0, '0, '0, 1, 1);

        // streaming 1,2,3 with out_ready held high
        for (int i = 1; i <= 3; i++) cycle(1, 0, 1, DW'(i), CW'(16'h10 + i), 1, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0, '0, 1, 1);

        // backpressure: A then B offered while stalled, then release
        cycle(1, 0, 1, 96'hA, 16'h0A0A, 0, 1);
        cycle(1, 0, 1, 96'hB, 16'h0B0B, 0, 1);
        cycle(1, 0, 1, 96'hB, 16'h0B0B, 0, 1);
        if (DEPTH == 2) cycle(1, 0, 0, '0, '0, 0, 1);
        else            cycle(1, 0, 1, 96'hB, 16'h0B0B, 1, 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, '0, '0, 1, 1);

        // flush from full with C offered; C must never appear
        cycle(1, 0, 1, 96'h1A, 16'h1111, 0, 1);
        cycle(1, 0, 1, 96'h1B, 16'h2222, 0, 1);
        cycle(1, 1, 1, 96'hC, 16'hCCCC, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0, '0, 1, 1);

        // flush while an output transfer completes
        cycle(1, 0, 1, 96'h2A, 16'h3333, 1, 1);
        cycle(1, 1, 1, 96'hC, 16'hCCCC, 1, 1);
        cycle(1, 0, 0, '0, '0, 1, 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom}, CW'($urandom),
                  ($urandom_range(0, 9) < 7), 1);
        end
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0, '0, 1, 1);

        // stall counter saturation, flush persistence and reset clear
        cycle(1, 0, 1, 96'h5, 16'h5555, 0, 1);
        for (int i = 0; i < 70000; i++) cycle(1, 0, 0, '0, '0, 0, (i % 8192) == 0);
        cycle(1, 0, 0, '0, '0, 0, 1);
        check_eq("stall_sat_model", 128'(stall_cnt), 128'(16'hFFFF));
        cycle(1, 0, 0, '0, '0, 0, 1);
        cycle(1, 1, 0, '0, '0, 0, 1);
        cycle(1, 0, 0, '0, '0, 0, 1);
        check_eq("stall_after_flush", 128'(stall_cnt), 128'(16'hFFFF));
        cycle(1, 0, 1, 96'h6, 16'h6666, 0, 1);
        cycle(0, 0, 1, 96'h7, 16'h7777, 0, 1);
        cycle(1, 0, 0, '0, '0, 1, 1);
        check_eq("stall_after_reset", 128'(stall_cnt), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 96, width of the datapath payload (operands, immediate, PC, register indices).
REQ-002 The block SHALL expose parameter CTRL_W, default 16, width of the control payload (ALU op, write enables, select lines).
REQ-003 The block SHALL expose port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL expose port reset  input  1  synchronous, active-low reset; reset=0 at a rising clk edge resets the block.
REQ-005 The block SHALL expose port flush  input  1  squash request (hazard/branch bubble insertion).
REQ-006 The block SHALL expose ports in_valid  input  1, in_ready  output  1, in_data  input  DATA_W, in_ctrl  input  CTRL_W  (upstream stage).
REQ-007 The block SHALL expose ports out_valid  output  1, out_ready  input  1, out_data  output  DATA_W, out_ctrl  output  CTRL_W  (downstream stage).
REQ-008 The block SHALL expose port occupancy  output  2  number of held entries (0..2).
REQ-009 The block SHALL expose port stall_cnt  output  16  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-010 An input transfer SHALL occur on a clk edge where in_valid=1 and in_ready=1; an output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-011 Data and ctrl of one input transfer SHALL appear together, unmodified, as one output entry; entry order SHALL be preserved.
REQ-012 Latency from input transfer to out_valid=1 SHALL be exactly 1 cycle when the block is empty.
REQ-013 The block SHALL sustain one transfer per cycle on both sides when out_ready is held at 1.
REQ-014 out_data, out_ctrl, out_valid SHALL be driven directly from registers (no combinational path from in_* to out_*).
REQ-015 out_ctrl SHALL read all zeros whenever out_valid=0 (bubble = no-op control).
REQ-016 When flush=1, in_ready SHALL be 0, no input transfer SHALL occur, and at that edge all held entries SHALL be discarded; the next cycle SHALL show out_valid=0, occupancy=0.
REQ-017 An output transfer in a flush cycle SHALL still complete (the downstream consumer sees the entry presented before the edge).
REQ-018 Input and output transfer on the same edge SHALL leave occupancy unchanged and advance the queue by one.
REQ-019 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, SHALL saturate at 16'hFFFF, and SHALL NOT be cleared by flush.
REQ-020 occupancy SHALL never exceed the configured depth (1 without skid, 2 with skid).

Reset
REQ-021 When reset=0 at a clk edge, all payload registers SHALL become 0, out_valid SHALL become 0, occupancy SHALL become 0, stall_cnt SHALL become 0.
REQ-022 reset SHALL take priority over flush and over any transfer in the same cycle; a reset asserted mid-stall SHALL discard held entries.
REQ-023 in_ready SHALL be 0 during any cycle with reset=0.

Configuration
REQ-024 Macro PIPE_STAGE_SKID_EN SHALL select the buffering mode.
REQ-025 With PIPE_STAGE_SKID_EN defined: two entries (main + skid); in_ready SHALL be a registered signal equal to !(skid full) and !flush-gated only by flush/reset; an input accepted while main is held and out_ready=0 SHALL go to skid; on the next output transfer skid SHALL move to main.
REQ-026 Without PIPE_STAGE_SKID_EN: one entry; in_ready SHALL equal (!out_valid | out_ready) & !flush & reset; occupancy[1] SHALL be constant 0.

Verification
REQ-027 Reset: reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0, stall_cnt=0, in_ready=0.
REQ-028 Streaming: out_ready=1, push in_data=1,2,3 in consecutive cycles -> out_data 1,2,3 on the following three cycles, out_valid=1 each, no gaps.
REQ-029 Backpressure (skid build): out_ready=0, push A then B -> occupancy 1 then 2, in_ready=0 after B, out_data=A; release out_ready -> A then B in order; without skid only A accepted, B held off by in_ready=0.
REQ-030 Flush: occupancy=2 and flush=1 with in_valid=1 in_data=C -> next cycle out_valid=0, occupancy=0, C never appears on outputs.
REQ-031 Stall counter: out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and holds; flush leaves it unchanged; reset=0 -> 0.
